// File: rtl/line_buffer_sched.sv
// line_buffer_sched
// Rotation controller for a 4-bank, 3-row line buffer. Steers accepted pixels
// into the bank being filled (zero-latency write path) and produces bank
// selects, hcount, centre-row vcount and valid aligned with the BRAM read
// latency.
// Optional feature macro: LBUF_PRIME_GATE_EN -- when defined, data_valid_out
// is suppressed until three full lines have been buffered after reset.

module line_buffer_sched #(
   parameter int HRES       = 320,
   parameter int VRES       = 240,
   parameter int ADDR_W     = $clog2(HRES),
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [10:0]           hcount_in,
   input  logic [9:0]            vcount_in,
   input  logic                  data_valid_in,
   output logic [3:0]            wr_en_out,
   output logic [ADDR_W-1:0]     wr_addr_out,
   output logic [ADDR_W-1:0]     rd_addr_out,
   output logic [2:0][1:0]       rd_sel_out,
   output logic [10:0]           hcount_out,
   output logic [9:0]            vcount_out,
   output logic                  data_valid_out,
   output logic                  primed_out
);

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  wrBank_q, wrBank_d;
   logic [1:0]  fillCnt_q, fillCnt_d;
   logic        primed_q;

   logic        accepted;
   logic        lineEnd;
   logic        validIn;
   logic [9:0]  vcountAdj;
   logic [2:0][1:0] selIn;

   logic [RD_LATENCY-1:0][10:0]     hPipe_q;
   logic [RD_LATENCY-1:0][9:0]      vPipe_q;
   logic [RD_LATENCY-1:0]           validPipe_q;
   logic [RD_LATENCY-1:0][2:0][1:0] selPipe_q;

   // Input qualification, write steering and the values entering the read pipeline
   always_comb begin
      accepted    = data_valid_in && (hcount_in < 11'(HRES));
      lineEnd     = accepted && (hcount_in == 11'(HRES - 1));
      wr_en_out   = (accepted && !rst_in) ? (4'b0001 << wrBank_q) : 4'b0000;
      wr_addr_out = hcount_in[ADDR_W-1:0];
      rd_addr_out = hcount_in[ADDR_W-1:0];
      selIn[0]    = wrBank_q - 2'd3;
      selIn[1]    = wrBank_q - 2'd2;
      selIn[2]    = wrBank_q - 2'd1;
      if (vcount_in >= 10'd2) begin
         vcountAdj = vcount_in - 10'd2;
      end else begin
         vcountAdj = vcount_in + 10'(VRES) - 10'd2;
      end
`ifdef LBUF_PRIME_GATE_EN
      validIn = accepted && (state_q == RUN);
`else
      validIn = accepted;
`endif
   end

   // Next-state logic: bank pointer and fill count advance only on a line end
   always_comb begin
      state_d   = state_q;
      wrBank_d  = wrBank_q;
      fillCnt_d = fillCnt_q;
      if (lineEnd) begin
         wrBank_d = wrBank_q + 2'd1;
         if (fillCnt_q != 2'd3) begin
            fillCnt_d = fillCnt_q + 2'd1;
         end
      end
      case (state_q)
         PRIME: begin
            if (lineEnd && (fillCnt_q == 2'd2)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = PRIME;
         end
      endcase
   end

   // Control state registers; primed_out is a registered view of the RUN state
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= PRIME;
         wrBank_q  <= 2'd0;
         fillCnt_q <= 2'd0;
         primed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrBank_q  <= wrBank_d;
         fillCnt_q <= fillCnt_d;
         primed_q  <= (state_q == RUN);
      end
   end

   // Read-side delay line matching BRAM read latency; shifts every cycle
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hPipe_q     <= '0;
         vPipe_q     <= '0;
         validPipe_q <= '0;
         selPipe_q   <= '0;
      end else begin
         hPipe_q[0]     <= hcount_in;
         vPipe_q[0]     <= vcountAdj;
         validPipe_q[0] <= validIn;
         selPipe_q[0]   <= selIn;
         for (int i = 1; i < RD_LATENCY; i++) begin
            hPipe_q[i]     <= hPipe_q[i-1];
            vPipe_q[i]     <= vPipe_q[i-1];
            validPipe_q[i] <= validPipe_q[i-1];
            selPipe_q[i]   <= selPipe_q[i-1];
         end
      end
   end

   assign hcount_out     = hPipe_q[RD_LATENCY-1];
   assign vcount_out     = vPipe_q[RD_LATENCY-1];
   assign data_valid_out = validPipe_q[RD_LATENCY-1];
   assign rd_sel_out     = selPipe_q[RD_LATENCY-1];
   assign primed_out     = primed_q;

endmodule

// File: tb/tb_line_buffer_sched.sv
// Testbench for line_buffer_sched (HRES=10, VRES=10). A reference model based
// on "completed lines since reset" predicts each slot's outputs; predictions
// are queued and a separate monitor compares them when due.

module tb_line_buffer_sched;

   localparam int HRES = 10;
   localparam int VRES = 10;
   localparam int AW   = $clog2(HRES);

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [10:0]     hcountIn = '0;
   logic [9:0]      vcountIn = '0;
   logic            validIn = 1'b0;
   logic [3:0]      wrEn;
   logic [AW-1:0]   wrAddr;
   logic [AW-1:0]   rdAddr;
   logic [2:0][1:0] rdSel;
   logic [10:0]     hcountOut;
   logic [9:0]      vcountOut;
   logic            validOut;
   logic            primed;

   typedef struct {
      int due;
      int wrEn;
      int addr;
   } combRec_t;

   typedef struct {
      int due;
      int h;
      int v;
      int valid;
      int top;
      int mid;
      int bot;
   } outRec_t;

   typedef struct {
      int due;
      int p;
   } primRec_t;

   combRec_t combQ[$];
   outRec_t  outQ[$];
   primRec_t primQ[$];

   int slot = -1;
   int linesDone = 0;
   int hpos = 0;
   int vline = 0;
   int checks = 0;
   int errors = 0;

   line_buffer_sched #(.HRES(HRES), .VRES(VRES)) dut (
      .clk_in(clock),
      .rst_in(reset),
      .hcount_in(hcountIn),
      .vcount_in(vcountIn),
      .data_valid_in(validIn),
      .wr_en_out(wrEn),
      .wr_addr_out(wrAddr),
      .rd_addr_out(rdAddr),
      .rd_sel_out(rdSel),
      .hcount_out(hcountOut),
      .vcount_out(vcountOut),
      .data_valid_out(validOut),
      .primed_out(primed)
   );

   // Free-running clock, 10 time-unit period
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s slot %0d: got %0d expected %0d", name, slot, act, exp);
      end
   endtask

   // Drive one slot at the falling edge and record the model's predictions
   task automatic applyStimulus(input logic rst, input logic valid, input int h, input int v);
      int bank;
      int acc;
      int gate;
      outRec_t o;
      @(negedge clock);
      slot++;
      reset    = rst;
      validIn  = valid;
      hcountIn = 11'(h);
      vcountIn = 10'(v);
      if (rst) begin
         combQ.delete();
         outQ.delete();
         primQ.delete();
         linesDone = 0;
         combQ.push_back('{slot, 0, h % (1 << AW)});
         for (int k = 0; k < 3; k++) outQ.push_back('{slot + k, 0, 0, 0, 0, 0, 0});
         for (int k = 0; k < 2; k++) primQ.push_back('{slot + k, 0});
      end else begin
         bank = linesDone % 4;
         acc  = (valid && h < HRES) ? 1 : 0;
`ifdef LBUF_PRIME_GATE_EN
         gate = (linesDone >= 3) ? 1 : 0;
`else
         gate = 1;
`endif
         combQ.push_back('{slot, acc ? (1 << bank) : 0, h % (1 << AW)});
         primQ.push_back('{slot + 1, (linesDone >= 3) ? 1 : 0});
         o.due   = slot + 2;
         o.h     = h;
         o.v     = (v >= 2) ? v - 2 : v + VRES - 2;
         o.valid = acc & gate;
         o.top   = (bank + 1) % 4;
         o.mid   = (bank + 2) % 4;
         o.bot   = (bank + 3) % 4;
         outQ.push_back(o);
         if (acc && h == HRES - 1) linesDone++;
      end
   endtask

   // One accepted pixel at the current raster position, then advance it
   task automatic pixel();
      applyStimulus(1'b0, 1'b1, hpos, vline);
      hpos++;
      if (hpos == HRES) begin
         hpos  = 0;
         vline = (vline + 1) % VRES;
      end
   endtask

   task automatic resetSlot();
      applyStimulus(1'b1, 1'b1, hpos, vline);
      hpos  = 0;
      vline = 0;
   endtask

   // Compare every prediction that falls due in the current slot
   task automatic checkOutput();
      while (combQ.size() > 0 && combQ[0].due <= slot) begin
         combRec_t c = combQ.pop_front();
         check("wr_en", int'(wrEn), c.wrEn);
         check("wr_addr", int'(wrAddr), c.addr);
         check("rd_addr", int'(rdAddr), c.addr);
      end
      while (outQ.size() > 0 && outQ[0].due <= slot) begin
         outRec_t o = outQ.pop_front();
         check("hcount_out", int'(hcountOut), o.h);
         check("vcount_out", int'(vcountOut), o.v);
         check("data_valid_out", int'(validOut), o.valid);
         check("rd_sel_top", int'(rdSel[0]), o.top);
         check("rd_sel_mid", int'(rdSel[1]), o.mid);
         check("rd_sel_bot", int'(rdSel[2]), o.bot);
      end
      while (primQ.size() > 0 && primQ[0].due <= slot) begin
         primRec_t p = primQ.pop_front();
         check("primed_out", int'(primed), p.p);
      end
   endtask

   // Monitor: samples 2 time units after each falling edge, clear of the rising edge
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (slot >= 0) checkOutput();
      end
   end

   // Directed sequence from the test plan followed by randomized traffic
   initial begin
      int r;
      resetSlot();
      resetSlot();
      repeat (30) pixel();
      repeat (4) pixel();
      repeat (5) applyStimulus(1'b0, 1'b0, hpos, vline);
      repeat (3) pixel();
      applyStimulus(1'b0, 1'b1, 12, vline);
      applyStimulus(1'b0, 1'b0, 0, vline);
      repeat (25) pixel();
      while (hpos != 6) pixel();
      resetSlot();
      repeat (45) pixel();
      repeat (900) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            resetSlot();
         end else if (r < 12) begin
            applyStimulus(1'b0, 1'b0, hpos, vline);
         end else if (r < 17) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(HRES, 2047), vline);
         end else begin
            pixel();
         end
      end
      applyStimulus(1'b0, 1'b0, 0, 0);
      repeat (3) begin
         @(negedge clock);
         slot++;
      end
      #4;
      check("queues_drained", combQ.size() + outQ.size() + primQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_buffer_sched.md
# line_buffer_sched

Controller for the 3-row line buffer used by the pixel filter path. It owns the rotation of four single-port-write/dual-read BRAM banks: it steers each incoming valid pixel into the bank being filled and selects which three banks feed the top/middle/bottom rows. It also produces hcount/vcount/valid delayed to match BRAM read latency. It sits between the camera pixel stream and the BRAM banks plus the 3-row output mux.

## Interface
- HRES, 320: pixels per line; BRAM depth.
- VRES, 240: lines per frame; used for vcount wrap.
- ADDR_W, $clog2(HRES): BRAM address width.
- RD_LATENCY, 2: BRAM read latency in cycles; fixed pipeline depth.
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  asynchronous, active-high reset.
- hcount_in  input  11  pixel column of current input.
- vcount_in  input  10  pixel row of current input.
- data_valid_in  input  1  input pixel valid this cycle.
- wr_en_out  output  4  one-hot bank write enable, combinational.
- wr_addr_out  output  ADDR_W  write address, combinational.
- rd_addr_out  output  ADDR_W  read address for all banks, combinational.
- rd_sel_out  output  [2:0][1:0]  bank index for [0]=top, [1]=mid, [2]=bottom; registered and aligned with BRAM data.
- hcount_out  output  11  hcount_in delayed RD_LATENCY cycles.
- vcount_out  output  10  centre-row line number, aligned with data.
- data_valid_out  output  1  aligned valid for the 3-row output.
- primed_out  output  1  high once 3 full lines have been written since reset.

## Operation
- Write pointer `wr_bank` (2 bits) is reset to 0.
- An accepted pixel needs data_valid_in=1 and hcount_in<HRES.
  - For an accepted pixel: wr_en_out = 1<<wr_bank, and wr_addr_out = rd_addr_out = hcount_in[ADDR_W-1:0].
  - Otherwise wr_en_out = 0. rd_addr_out still tracks hcount_in.
- Line end is an accepted pixel with hcount_in==HRES-1. On line end:
  - wr_bank increments modulo 4 on the next edge.
  - fill_cnt increments, saturating at 3.
- Read selects are computed from the current wr_bank and are all modulo 4:
  - bottom = wr_bank-1
  - mid = wr_bank-2
  - top = wr_bank-3
- Read selects, hcount, valid and vcount pass through RD_LATENCY register stages.
- vcount arithmetic is performed at input: vcount_in-2 if vcount_in≥2, else vcount_in+VRES-2.
- FSM states:
  - PRIME (reset state): fill_cnt<3. Moves to RUN on the line end that makes fill_cnt=3.
  - RUN: absorbing. Only reset leaves it.
- primed_out = (state==RUN), registered.
- data_valid_out: delayed copy of (data_valid_in && hcount_in<HRES), subject to the Configuration gate.
- Out-of-range hcount_in≥HRES with valid=1:
  - no write, no pointer advance;
  - data_valid_out=0 for that slot.
- Gaps in data_valid_in freeze wr_bank and fill_cnt; the pipeline keeps shifting.

## Timing
- Reset values:
  - wr_bank=0, fill_cnt=0, state=PRIME.
  - All pipeline registers 0, so hcount_out=0, vcount_out=0, rd_sel_out all 0, data_valid_out=0, primed_out=0.
  - wr_en_out is forced 0 while rst_in=1.
- Write path: zero latency. Enable and address are valid in the same cycle as the pixel.
- Output path: exactly RD_LATENCY (2) cycles from input pixel to hcount_out/vcount_out/data_valid_out/rd_sel_out.
- Line-end pointer update:
  - the pixel at HRES-1 is written to the old bank;
  - the next cycle's pixel, i.e. next-line hcount 0, goes to the new bank.
- Line end with continuous valid: write to bank k at cycle t; first pixel of next line to bank k+1 at t+1; no bubble.
- Wrap: wr_bank 3→0. The rd_sel mapping stays consistent modulo 4.
- Reset asserted mid-line clears everything asynchronously. The first line after release is written to bank 0 and the block re-enters PRIME.
- Frame boundary (vcount_in wraps to 0) has no special effect on pointer or fill_cnt.

## Configuration
- LBUF_PRIME_GATE_EN defined: data_valid_out is additionally ANDed with the state==RUN value sampled at input time (pipelined with the data). No output is valid until 3 full lines are buffered after reset.
- Not defined: data_valid_out is the pure delayed input valid. primed_out still functions as a status bit.

## Test plan
- Reset, then 30 continuous valid pixels, HRES=10, VRES=10, starting at vcount 0 → wr_en_out = 0001 for pixels 0–9, 0010 for 10–19, 0100 for 20–29; primed_out rises 2 cycles after pixel 29 (one edge to enter RUN, one for the registered output).
- Steady state with wr_bank=1 → rd_sel_out 2 cycles later: top=2, mid=3, bottom=0. After 4 more lines the same mapping recurs (wrap check).
- vcount_in=0 then 1, VRES=10 → vcount_out=8 then 9, 2 cycles later; vcount_in=5 → vcount_out=3.
- data_valid_in low for 5 cycles mid-line at hcount 4 → wr_en_out=0 and wr_bank unchanged during the gap; data_valid_out low for the matching 5 slots.
- hcount_in=12 (≥HRES) with valid=1 → wr_en_out=0, no pointer advance, data_valid_out=0 two cycles later.
- rst_in pulsed at hcount 6 of line 2 → all outputs 0 immediately; next line writes bank 0; with LBUF_PRIME_GATE_EN, data_valid_out stays 0 until 3 lines complete.
